// File: rtl/simple_eval_arbiter.sv
// simple_eval_arbiter
// Round-robin arbiter that time-shares one external f = (a & b) | ~c
// evaluator between NREQ requesters. Each transaction is two cycles:
// GRANT drives the operands, RESP returns the captured result.
//
// Optional build macro SIMPLE_EVAL_ARB_CHECK_EN: when defined, the evaluator
// result is cross-checked in GRANT and a sticky err flag is raised on any
// mismatch. When undefined, err is tied low and no checker logic exists.
module simple_eval_arbiter #(
  parameter int NREQ = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [3*NREQ-1:0] req_abc,
  output logic [NREQ-1:0]   gnt,
  output logic              eval_a,
  output logic              eval_b,
  output logic              eval_c,
  input  logic              eval_f,
  output logic [NREQ-1:0]   rsp_valid,
  output logic              rsp_f,
  output logic              busy,
  output logic              err
);

  localparam int IDX_W = (NREQ > 2) ? $clog2(NREQ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic              load_s;
  logic              found_s;
  logic [IDX_W-1:0]  last_winner_r;
  logic [IDX_W-1:0]  winner_s;
  logic [IDX_W-1:0]  cand_s;
  logic [NREQ-1:0]   winner_oh_s;
  logic [2:0]        abc_s;
  logic [NREQ-1:0]   gnt_r;
  logic [NREQ-1:0]   rsp_valid_r;
  logic              eval_a_r;
  logic              eval_b_r;
  logic              eval_c_r;
  logic              rsp_f_r;
  logic              busy_r;
  logic              err_r;

  // Round-robin search starting just after the previous winner.
  always_comb begin
    found_s  = 1'b0;
    winner_s = last_winner_r;
    cand_s   = (last_winner_r == LAST_IDX) ? IDX_ZERO : last_winner_r + IDX_ONE;
    for (int k = 0; k < NREQ; k++) begin
      if (!found_s && req[cand_s]) begin
        found_s  = 1'b1;
        winner_s = cand_s;
      end else begin
        found_s  = found_s;
      end
      cand_s = (cand_s == LAST_IDX) ? IDX_ZERO : cand_s + IDX_ONE;
    end
  end

  // Decode the winner into a one-hot grant and select its operand slice.
  always_comb begin
    winner_oh_s = {NREQ{1'b0}};
    abc_s       = 3'b000;
    for (int k = 0; k < NREQ; k++) begin
      if (IDX_W'(k) == winner_s) begin
        winner_oh_s[k] = 1'b1;
        abc_s          = req_abc[3*k +: 3];
      end else begin
        winner_oh_s[k] = 1'b0;
      end
    end
  end

  // Next-state logic; load_s marks the edge that starts a new transaction.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          state_nxt_s = GRANT;
          load_s      = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GRANT: begin
        state_nxt_s = RESP;
      end
      RESP: begin
        if (found_s) begin
          state_nxt_s = GRANT;
          load_s      = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Grant, operand, response and busy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_r         <= {NREQ{1'b0}};
      rsp_valid_r   <= {NREQ{1'b0}};
      rsp_f_r       <= 1'b0;
      eval_a_r      <= 1'b0;
      eval_b_r      <= 1'b0;
      eval_c_r      <= 1'b0;
      busy_r        <= 1'b0;
      last_winner_r <= LAST_IDX;
    end else begin
      busy_r <= (state_nxt_s != IDLE);
      if (load_s) begin
        gnt_r         <= winner_oh_s;
        eval_a_r      <= abc_s[2];
        eval_b_r      <= abc_s[1];
        eval_c_r      <= abc_s[0];
        last_winner_r <= winner_s;
      end else begin
        gnt_r <= {NREQ{1'b0}};
      end
      // Leaving GRANT: the evaluator output belongs to the granted requester.
      if (state_r == GRANT) begin
        rsp_valid_r <= gnt_r;
        rsp_f_r     <= eval_f;
      end else begin
        rsp_valid_r <= {NREQ{1'b0}};
      end
    end
  end

`ifdef SIMPLE_EVAL_ARB_CHECK_EN
  // Reference model of the shared evaluator.
  function automatic logic eval_ref(input logic a, input logic b, input logic c);
    return (a & b) | ~c;
  endfunction

  // Sticky flag for an evaluator result that disagrees with the reference.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else if ((state_r == GRANT) && (eval_f != eval_ref(eval_a_r, eval_b_r, eval_c_r))) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end
`else
  assign err_r = 1'b0;
`endif

  assign gnt       = gnt_r;
  assign eval_a    = eval_a_r;
  assign eval_b    = eval_b_r;
  assign eval_c    = eval_c_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_f     = rsp_f_r;
  assign busy      = busy_r;
  assign err       = err_r;

endmodule

// File: tb/tb_simple_eval_arbiter.sv
// Testbench for simple_eval_arbiter (NREQ = 4). Expected responses are
// queued when a request is issued and matched against each rsp_valid pulse.
module tb_simple_eval_arbiter;

  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [3*NREQ-1:0] req_abc;
  logic [NREQ-1:0]   gnt;
  logic              eval_a;
  logic              eval_b;
  logic              eval_c;
  logic              eval_f;
  logic [NREQ-1:0]   rsp_valid;
  logic              rsp_f;
  logic              busy;
  logic              err;
  logic              bad_f;

  // f for abc = 000..111 is 1,0,1,0,1,0,1,1 (bit index = abc)
  logic [7:0] tt_f = 8'b1101_0101;

  typedef struct {
    int   idx;
    logic f;
  } exp_t;

  exp_t sb_q[$];
  exp_t e_m;

  int n_checks = 0;
  int n_errors = 0;

  simple_eval_arbiter #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_abc   (req_abc),
    .gnt       (gnt),
    .eval_a    (eval_a),
    .eval_b    (eval_b),
    .eval_c    (eval_c),
    .eval_f    (eval_f),
    .rsp_valid (rsp_valid),
    .rsp_f     (rsp_f),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Shared evaluator; bad_f forces a wrong (zero) result.
  assign eval_f = bad_f ? 1'b0 : ((eval_a & eval_b) | ~eval_c);

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slice(input int i, input logic [2:0] abc);
    req_abc[3*i +: 3] = abc;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // One isolated transaction from IDLE with cycle-1/2 timing checks.
  task automatic one_txn(input int i, input logic [2:0] abc);
    exp_t e;
    set_slice(i, abc);
    req = 4'b0001 << i;
    e.idx = i;
    e.f   = bad_f ? 1'b0 : tt_f[abc];
    sb_q.push_back(e);
    step();
    check_eq("txn_gnt", gnt, 32'(4'b0001 << i));
    check_eq("txn_abc", {eval_a, eval_b, eval_c}, abc);
    check_eq("txn_busy1", busy, 1);
    req = 4'b0000;
    step();
    check_eq("txn_rsp", rsp_valid, 32'(4'b0001 << i));
    check_eq("txn_gnt0", gnt, 0);
    step();
    check_eq("txn_idle", busy, 0);
    check_eq("txn_hold", {eval_a, eval_b, eval_c}, abc);
  endtask

  // Scoreboard monitor and one-hot invariants.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check_eq("gnt_1hot", $onehot0(gnt), 1);
      check_eq("rsp_1hot", $onehot0(rsp_valid), 1);
      if (rsp_valid != 4'b0000) begin
        if (sb_q.size() == 0) begin
          check_eq("rsp_unexpected", rsp_valid, 0);
        end else begin
          e_m = sb_q.pop_front();
          check_eq("sb_rsp_valid", rsp_valid, 32'(4'b0001 << e_m.idx));
          check_eq("sb_rsp_f", rsp_f, e_m.f);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    rst_n   = 1'b0;
    req     = 4'b0000;
    req_abc = 12'h000;
    bad_f   = 1'b0;
    step();
    step();
    // Reset values
    check_eq("rst_gnt", gnt, 0);
    check_eq("rst_rsp", rsp_valid, 0);
    check_eq("rst_rsp_f", rsp_f, 0);
    check_eq("rst_abc", {eval_a, eval_b, eval_c}, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_err", err, 0);
    rst_n = 1'b1;
    step();

    // Single request
    one_txn(0, 3'b110);

    // Truth table through requester 2
    for (int v = 0; v < 8; v++) begin
      one_txn(2, 3'(v));
    end

    // Round robin after reset: all four held for eight results
    do_reset();
    step();
    set_slice(0, 3'b110);
    set_slice(1, 3'b001);
    set_slice(2, 3'b010);
    set_slice(3, 3'b101);
    for (int n = 0; n < 8; n++) begin
      e.idx = n % 4;
      e.f   = tt_f[req_abc[3*(n % 4) +: 3]];
      sb_q.push_back(e);
    end
    req = 4'b1111;
    for (int c = 1; c <= 16; c++) begin
      step();
      if ((c % 2) == 1) begin
        check_eq("rr_gnt", gnt, 32'(4'b0001 << (((c - 1) / 2) % 4)));
        check_eq("rr_gnt_norsp", rsp_valid, 0);
      end else begin
        check_eq("rr_rsp", rsp_valid, 32'(4'b0001 << (((c - 2) / 2) % 4)));
        check_eq("rr_rsp_nognt", gnt, 0);
      end
    end
    req = 4'b0000;
    step();
    check_eq("rr_idle", busy, 0);

    // Drop / re-request: req0 held, req3 once, dropped in its GRANT cycle
    e.idx = 0; e.f = 1'b1; sb_q.push_back(e);
    e.idx = 3; e.f = 1'b0; sb_q.push_back(e);
    e.idx = 0; e.f = 1'b1; sb_q.push_back(e);
    req = 4'b1001;
    step();
    check_eq("dr_gnt0", gnt, 32'(4'b0001));
    step();
    check_eq("dr_rsp0", rsp_valid, 32'(4'b0001));
    step();
    check_eq("dr_gnt3", gnt, 32'(4'b1000));
    req = 4'b0001;
    step();
    check_eq("dr_rsp3", rsp_valid, 32'(4'b1000));
    step();
    check_eq("dr_gnt0b", gnt, 32'(4'b0001));
    req = 4'b0000;
    step();
    check_eq("dr_rsp0b", rsp_valid, 32'(4'b0001));
    step();
    check_eq("dr_idle", busy, 0);

    // Reset during GRANT aborts the transaction
    set_slice(2, 3'b111);
    req = 4'b0100;
    step();
    check_eq("mr_gnt", gnt, 32'(4'b0100));
    rst_n = 1'b0;
    #1;
    check_eq("mr_gnt0", gnt, 0);
    check_eq("mr_busy0", busy, 0);
    check_eq("mr_abc0", {eval_a, eval_b, eval_c}, 0);
    check_eq("mr_rsp0", rsp_valid, 0);
    req = 4'b0000;
    step();
    check_eq("mr_norsp", rsp_valid, 0);
    step();
    rst_n = 1'b1;
    step();
    one_txn(1, 3'b011);

    // Evaluator cross-check
    check_eq("chk_err_pre", err, 0);
    bad_f = 1'b1;
    one_txn(1, 3'b000);
    bad_f = 1'b0;
`ifdef SIMPLE_EVAL_ARB_CHECK_EN
    check_eq("chk_err_set", err, 1);
`else
    check_eq("chk_err_off", err, 0);
`endif
    one_txn(3, 3'b110);
`ifdef SIMPLE_EVAL_ARB_CHECK_EN
    check_eq("chk_err_sticky", err, 1);
`else
    check_eq("chk_err_off2", err, 0);
`endif
    do_reset();
    step();
    check_eq("chk_err_clr", err, 0);

    check_eq("sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
